seg_display_capture: RTL

- Receive side of the multiplexed 7-segment interface: samples the active-low anode-select and segment lines driven by our display drivers and reconstructs the displayed digit values.
- Used for board loopback self-test and as a bench monitor for the display drivers.
- Also converts the two lowest digits (ones and tens) to a binary value.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg_display_capture.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment definitions. Active-low segment patterns
//                {a,b,c,d,e,f,g}, special nibble codes, the capture FSM state
//                type and the matching pattern encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_BLANK = 4'hE;
    localparam logic [3:0] DIG_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } cap_state_e;

    // Nibble to segment pattern; anything outside 0-9 shows blank
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7_encode = SEG_0;
            4'd1:    seg7_encode = SEG_1;
            4'd2:    seg7_encode = SEG_2;
            4'd3:    seg7_encode = SEG_3;
            4'd4:    seg7_encode = SEG_4;
            4'd5:    seg7_encode = SEG_5;
            4'd6:    seg7_encode = SEG_6;
            4'd7:    seg7_encode = SEG_7;
            4'd8:    seg7_encode = SEG_8;
            4'd9:    seg7_encode = SEG_9;
            default: seg7_encode = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational active-low 7-segment pattern to nibble decoder.
//                0-9 for digits, DIG_BLANK for all-off, DIG_BAD otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit
);

    // Table lookup of the displayed pattern
    always_comb begin
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: o_digit = DIG_BLANK;
            default:   o_digit = DIG_BAD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_capture
//  Description : Samples multiplexed active-low anode/segment lines, waits for
//                a stable window, and rebuilds the displayed digits. Also
//                forms tens*10+ones from digits 1 and 0 and declares all
//                digits stale after a long period without any capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   Anode_in,
    input  logic [6:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    capture_stb,
    output logic                    pattern_err,
    output logic                    multi_sel_err,
    output logic                    timeout,
    output logic [6:0]              value_bin,
    output logic                    value_valid
);

    localparam int c_WW  = NUM_DIGITS + 7;
    localparam int c_SCW = $clog2(STABLE_CYCLES);
    localparam int c_TCW = $clog2(TIMEOUT_CYCLES);
    localparam int c_IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Transition fires on the edge that would load STABLE_CYCLES-1
    localparam logic [c_SCW-1:0] c_STAB_LAST = c_SCW'(STABLE_CYCLES - 2);
    localparam logic [c_TCW-1:0] c_TO_LAST   = c_TCW'(TIMEOUT_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   r_anode_m, r_anode_s;
    logic [6:0]              r_seg_m, r_seg_s;
    logic [c_WW-1:0]         w_word, r_prev_word, r_held_word;
    logic                    r_held_ok;
    logic                    w_changed;
    cap_state_e              r_state, w_state_nxt;
    logic [c_SCW-1:0]        r_stab_cnt;
    logic [c_TCW-1:0]        r_to_cnt;
    logic                    w_any_low, w_multi_low;
    logic [c_IW-1:0]         w_low_idx;
    logic                    w_stable_done, w_held_match;
    logic                    w_capture, w_multi_err, w_go_idle, w_to_fire;
    logic [3:0]              w_dec;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_cap_stb, r_pat_err, r_multi_err, r_timeout;
    logic                    r_cap_low;
    logic [6:0]              r_value, w_val_calc;
    logic                    r_value_valid, w_val_ok;

    // Two-flop synchronizers on the pin inputs
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_anode_m <= '0;
            r_anode_s <= '0;
            r_seg_m   <= '0;
            r_seg_s   <= '0;
        end else begin
            r_anode_m <= Anode_in;
            r_anode_s <= r_anode_m;
            r_seg_m   <= seg_in;
            r_seg_s   <= r_seg_m;
        end
    end

    assign w_word    = {r_anode_s, r_seg_s};
    assign w_changed = (w_word != r_prev_word);

    // Previous synchronized sample, used for change detection and as the
    // stable word once the settle window completes
    always_ff @(posedge Clock) begin
        if (reset) r_prev_word <= '0;
        else       r_prev_word <= w_word;
    end

    // Classify the anode part of the stable word: any low, several low, index
    always_comb begin
        w_any_low   = 1'b0;
        w_multi_low = 1'b0;
        w_low_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_prev_word[7+i]) begin
                if (w_any_low) w_multi_low = 1'b1;
                w_any_low = 1'b1;
                w_low_idx = c_IW'(i);
            end
        end
    end

    seg7_decode u_decode (
        .i_seg   (r_prev_word[6:0]),
        .o_digit (w_dec)
    );

    assign w_stable_done = (r_state == ST_SETTLE) && !w_changed && (r_stab_cnt == c_STAB_LAST);
    // A glitch that returns to the word already handled goes back to HOLD
    assign w_held_match  = r_held_ok && (r_prev_word == r_held_word);

    // FSM state register
    always_ff @(posedge Clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_changed) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (w_stable_done) begin
                    if (!w_any_low)                      w_state_nxt = ST_IDLE;
                    else if (w_held_match || w_multi_low) w_state_nxt = ST_HOLD;
                    else                                  w_state_nxt = ST_CAPTURE;
                end
            end
            // A change arriving during the capture cycle must not be lost
            ST_CAPTURE: w_state_nxt = w_changed ? ST_SETTLE : ST_HOLD;
            ST_HOLD:    if (w_changed) w_state_nxt = ST_SETTLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_capture   = (r_state == ST_CAPTURE);
        w_multi_err = w_stable_done && w_any_low && w_multi_low && !w_held_match;
        w_go_idle   = w_stable_done && !w_any_low;
        w_to_fire   = (r_to_cnt == c_TO_LAST) && !w_capture;
    end

    // Stability counter: runs only while the sample is unchanged in SETTLE
    always_ff @(posedge Clock) begin
        if (reset)                                      r_stab_cnt <= '0;
        else if ((r_state == ST_SETTLE) && !w_changed)  r_stab_cnt <= r_stab_cnt + 1'b1;
        else                                            r_stab_cnt <= '0;
    end

    // Remember the last word that was captured or flagged
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_held_word <= '0;
            r_held_ok   <= 1'b0;
        end else if (w_capture || w_multi_err) begin
            r_held_word <= r_prev_word;
            r_held_ok   <= 1'b1;
        end else if (w_go_idle || w_to_fire) begin
            r_held_ok   <= 1'b0;
        end
    end

    // Digit store, strobes and staleness timer; capture beats timeout
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_digits    <= {NUM_DIGITS{DIG_BAD}};
            r_valid     <= '0;
            r_cap_stb   <= 1'b0;
            r_pat_err   <= 1'b0;
            r_multi_err <= 1'b0;
            r_timeout   <= 1'b0;
            r_cap_low   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_cap_stb   <= w_capture;
            r_pat_err   <= w_capture && (w_dec == DIG_BAD);
            r_multi_err <= w_multi_err;
            r_timeout   <= w_to_fire;
            r_cap_low   <= w_capture && (w_low_idx <= c_IW'(1));
            if (w_capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_low_idx == c_IW'(i)) begin
                        r_digits[4*i +: 4] <= w_dec;
                        r_valid[i]         <= 1'b1;
                    end
                end
                r_to_cnt <= '0;
            end else if (w_to_fire) begin
                r_digits <= {NUM_DIGITS{DIG_BAD}};
                r_valid  <= '0;
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign w_val_ok   = (&r_valid[1:0]) && (r_digits[3:0] <= 4'd9) && (r_digits[7:4] <= 4'd9);
    assign w_val_calc = 7'(r_digits[7:4]) * 7'd10 + 7'(r_digits[3:0]);

    // Binary value of the two low digits, refreshed after a low-slot capture
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else if (w_to_fire || !w_val_ok) begin
            r_value_valid <= 1'b0;
        end else if (r_cap_stb && r_cap_low) begin
            r_value       <= w_val_calc;
            r_value_valid <= 1'b1;
        end
    end

    assign digits_out    = r_digits;
    assign digit_valid   = r_valid;
    assign capture_stb   = r_cap_stb;
    assign pattern_err   = r_pat_err;
    assign multi_sel_err = r_multi_err;
    assign timeout       = r_timeout;
    assign value_bin     = r_value;
    assign value_valid   = r_value_valid;

endmodule
`default_nettype wire
